// File: rtl/part_select_pkg.sv
// part_select_pkg: shared FSM state type and field-count/index-width helpers for the part-select serializer
package part_select_pkg;
  typedef enum logic [0:0] {IDLE, EMIT} state_t;
  function automatic int calc_nf(input int data_w, input int field_w);
    return data_w / field_w;
  endfunction
  function automatic int calc_idx_w(input int data_w, input int field_w);
    return $clog2(calc_nf(data_w, field_w)) + 1;
  endfunction
endpackage

// File: rtl/part_select_serializer_field_mux.sv
// field_mux: picks one FIELD_W slice of a word by index, walking up from the LSB or down from the MSB
module field_mux
  import part_select_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FIELD_W = 8,
  parameter int IDX_W = calc_idx_w(DATA_W, FIELD_W)
) (
  input  logic [DATA_W-1:0]  i_word,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic               i_msb_first,
  output logic [FIELD_W-1:0] o_field
);
  localparam int AW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  logic [AW-1:0] w_lo, w_hi;
  assign w_lo = AW'(i_idx * FIELD_W);
  assign w_hi = AW'(DATA_W - 1 - i_idx * FIELD_W);
  assign o_field = i_msb_first ? i_word[w_hi -: FIELD_W] : i_word[w_lo +: FIELD_W];
endmodule

// File: rtl/part_select_serializer.sv
// part_select_serializer: splits a signed word into unsigned FIELD_W fields, one per cycle, LSB- or MSB-first.
// Optional out_sign port (captured word's sign bit) enabled by macro PART_SELECT_SER_SIGN_EN.
module part_select_serializer
  import part_select_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FIELD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_msb_first,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FIELD_W-1:0]       out_data,
  output logic                     out_last
`ifdef PART_SELECT_SER_SIGN_EN
  ,
  output logic                     out_sign
`endif
);
  localparam int NF = calc_nf(DATA_W, FIELD_W);
  localparam int IW = calc_idx_w(DATA_W, FIELD_W);
  if (FIELD_W < 1 || FIELD_W > DATA_W || DATA_W % FIELD_W != 0) begin : g_param_err
    $error("part_select_serializer: FIELD_W must divide DATA_W and not exceed it");
  end
  state_t            r_state;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_word;
  logic              r_msb;
  logic              w_last_idx, w_accept;
  assign w_last_idx = r_idx == IW'(NF - 1);
  assign out_valid  = r_state == EMIT;
  assign out_last   = out_valid & w_last_idx;
  // The only combinational ready path: a finishing word frees the slot in the same cycle
  assign in_ready   = rst_n & ((r_state == IDLE) | (out_valid & w_last_idx & out_ready));
  assign w_accept   = in_valid & in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_word  <= '0;
      r_msb   <= 1'b0;
    end else if (w_accept) begin
      r_state <= EMIT;
      r_idx   <= '0;
      r_word  <= in_data;
      r_msb   <= in_msb_first;
    end else if (out_valid & out_ready) begin
      if (w_last_idx) r_state <= IDLE;
      else r_idx <= r_idx + IW'(1);
    end
  end
  field_mux #(.DATA_W(DATA_W), .FIELD_W(FIELD_W), .IDX_W(IW)) u_field_mux (
    .i_word      (r_word),
    .i_idx       (r_idx),
    .i_msb_first (r_msb),
    .o_field     (out_data)
  );
`ifdef PART_SELECT_SER_SIGN_EN
  logic r_sign;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sign <= 1'b0;
    else if (w_accept) r_sign <= in_data[DATA_W-1];
  end
  assign out_sign = out_valid & r_sign;
`endif
endmodule

// File: tb/tb_part_select_serializer.sv
// tb_part_select_serializer: scoreboard bench driving a 32/8 and a 32/32 instance from shared stimulus
module tb_part_select_serializer;
  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        s;
  } exp_t;
  logic clk, rst_n, in_valid, in_msb_first, out_ready;
  logic [31:0] in_data;
  logic a_in_ready, a_out_valid, a_out_last;
  logic [7:0] a_out_data;
  logic b_in_ready, b_out_valid, b_out_last;
  logic [31:0] b_out_data;
`ifdef PART_SELECT_SER_SIGN_EN
  logic a_out_sign, b_out_sign;
`endif
  exp_t qa[$], qb[$];
  int n_chk = 0, n_pass = 0;
  part_select_serializer #(.DATA_W(32), .FIELD_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_msb_first(in_msb_first), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_last(a_out_last)
`ifdef PART_SELECT_SER_SIGN_EN
    , .out_sign(a_out_sign)
`endif
  );
  part_select_serializer #(.DATA_W(32), .FIELD_W(32)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_msb_first(in_msb_first), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_last(b_out_last)
`ifdef PART_SELECT_SER_SIGN_EN
    , .out_sign(b_out_sign)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      logic busy;
      int sh;
      busy = qa.size() != 0;
      chk("a_valid", 32'(a_out_valid), 32'(busy));
      chk("a_in_ready", 32'(a_in_ready), 32'(busy ? (qa[0].l & out_ready) : 1'b1));
      if (a_out_valid && busy) begin
        chk("a_data", 32'(a_out_data), qa[0].d);
        chk("a_last", 32'(a_out_last), 32'(qa[0].l));
`ifdef PART_SELECT_SER_SIGN_EN
        chk("a_sign", 32'(a_out_sign), 32'(qa[0].s));
`endif
        if (out_ready) void'(qa.pop_front());
      end
      if (in_valid && a_in_ready)
        for (int k = 0; k < 4; k++) begin
          sh = in_msb_first ? 24 - 8 * k : 8 * k;
          qa.push_back('{d: (in_data >> sh) & 32'hFF, l: (k == 3), s: in_data[31]});
        end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      logic busy;
      busy = qb.size() != 0;
      chk("b_valid", 32'(b_out_valid), 32'(busy));
      chk("b_in_ready", 32'(b_in_ready), 32'(busy ? out_ready : 1'b1));
      if (b_out_valid && busy) begin
        chk("b_data", b_out_data, qb[0].d);
        chk("b_last", 32'(b_out_last), 32'(qb[0].l));
`ifdef PART_SELECT_SER_SIGN_EN
        chk("b_sign", 32'(b_out_sign), 32'(qb[0].s));
`endif
        if (out_ready) void'(qb.pop_front());
      end
      if (in_valid && b_in_ready) qb.push_back('{d: in_data, l: 1'b1, s: in_data[31]});
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] w, input logic m);
    bit acc = 0;
    in_valid = 1'b1;
    in_data = w;
    in_msb_first = m;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = a_in_ready;
      step();
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask
  task automatic rst_outputs_zero();
    chk("rst_a_ready", 32'(a_in_ready), 32'd0);
    chk("rst_a_valid", 32'(a_out_valid), 32'd0);
    chk("rst_a_data", 32'(a_out_data), 32'd0);
    chk("rst_a_last", 32'(a_out_last), 32'd0);
    chk("rst_b_ready", 32'(b_in_ready), 32'd0);
    chk("rst_b_data", b_out_data, 32'd0);
`ifdef PART_SELECT_SER_SIGN_EN
    chk("rst_a_sign", 32'(a_out_sign), 32'd0);
`endif
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_msb_first = 1'b0;
    out_ready = 1'b1;
    step();
    rst_outputs_zero();
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(a_in_ready), 32'd1);
    step();
    send(32'h8012_34F6, 1'b0);
    in_valid = 1'b0;
    repeat (6) step();
    send(32'h8012_34F6, 1'b1);
    in_valid = 1'b0;
    repeat (6) step();
    send(32'h8012_34F6, 1'b0);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_hold", 32'(a_out_data), 32'h34);
    end
    out_ready = 1'b1;
    repeat (6) step();
    send(32'hA1B2_C3D4, 1'b0);
    send(32'h1122_3344, 1'b1);
    in_valid = 1'b0;
    repeat (6) step();
    send(32'hDEAD_BEEF, 1'b0);
    step();
    step();
    chk("pre_rst_field2", 32'(a_out_data), 32'hAD);
    rst_n = 1'b0;
    #1;
    rst_outputs_zero();
    qa.delete();
    qb.delete();
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(a_in_ready), 32'd1);
    step();
    send(32'hCAFE_0123, 1'b0);
    in_valid = 1'b0;
    repeat (6) step();
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h7FFF_0001, 1'b1);
    for (int i = 0; i < 4; i++) send($urandom, 1'($urandom_range(1)));
    in_valid = 1'b0;
    for (int n = 0; n < 100 && (qa.size() != 0 || qb.size() != 0); n++) step();
    chk("drain", 32'(qa.size() + qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/part_select_serializer.md
PART_SELECT_SERIALIZER -- requirements
Module: part_select_serializer

Interface
REQ-001 Parameter DATA_W, default 32: width of the signed input word.
REQ-002 Parameter FIELD_W, default 8: width of each emitted field; DATA_W % FIELD_W == 0 and FIELD_W <= DATA_W are required, with an elaboration-time error otherwise.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  input word offered.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 in_data  input  signed [DATA_W-1:0]  word to split.
REQ-008 in_msb_first  input  1  selects field order: 0 = LSB-first (+: select), 1 = MSB-first (-: select).
REQ-009 out_valid  output  1  field present.
REQ-010 out_ready  input  1  downstream consumes the field.
REQ-011 out_data  output  unsigned [FIELD_W-1:0]  current field.
REQ-012 out_last  output  1  current field is the final field of its word.

Function
REQ-013 NF = DATA_W/FIELD_W fields per word; the field index counter shall be $clog2(NF)+1 bits wide, so it never wraps within a word.
REQ-014 FSM states: IDLE and EMIT only.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, the word and in_msb_first are captured, idx=0, and the FSM moves to EMIT.
REQ-016 EMIT: out_valid=1; out_data = word[idx*FIELD_W +: FIELD_W] when LSB-first, word[DATA_W-1-idx*FIELD_W -: FIELD_W] when MSB-first.
REQ-017 out_data is unsigned per LRM 11.8.1: no sign extension or sign interpretation is applied, including to the field holding the original sign bit.
REQ-018 out_last=1 exactly when out_valid=1 and idx==NF-1.
REQ-019 EMIT with out_ready=1 and idx<NF-1: idx increments.
REQ-020 EMIT with out_ready=1 and idx==NF-1: if in_valid=1, the next word is captured in the same cycle (in_ready=1) with idx=0 and the FSM stays in EMIT; otherwise the FSM returns to IDLE.
REQ-021 in_ready = (state==IDLE) | (state==EMIT & idx==NF-1 & out_ready); this is the only combinational ready path.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_last and idx are held stable.
REQ-023 Latency: the first field is valid on the cycle after acceptance; sustained throughput is one field per cycle, with no bubble between words.
REQ-024 NF==1: each word produces a single field with out_last=1, and the back-to-back rule of REQ-020 still applies.

Reset
REQ-025 While rst_n=0: state=IDLE, idx=0, captured word=0, out_valid=0, out_last=0, out_data=0, in_ready=0.
REQ-026 Reset asserted mid-word discards the remaining fields; after deassertion the block is in IDLE with in_ready=1 on the first clock.

Configuration
REQ-027 Macro PART_SELECT_SER_SIGN_EN.
REQ-028 With PART_SELECT_SER_SIGN_EN defined: an extra output port out_sign (1 bit) is added, equal to bit DATA_W-1 of the captured word whenever out_valid=1, and 0 otherwise and in reset; this lets downstream rebuild signedness.
REQ-029 Without PART_SELECT_SER_SIGN_EN: the out_sign port and its register do not exist, and all other behaviour is identical.

Structure
REQ-030 Shared package part_select_pkg holds the state enum typedef (IDLE, EMIT) and the localparam function computing NF and the index width.
REQ-031 One sub-module, field_mux, is permitted: a combinational index/order-to-field selector, instantiated once.

Verification (DATA_W=32, FIELD_W=8)
REQ-032 Accept 32'sh8012_34F6 with in_msb_first=0 and out_ready=1 -> out_data F6, 34, 12, 80 on consecutive cycles, out_last on 80, and 80 never sign-extended.
REQ-033 Same word with in_msb_first=1 -> 80, 12, 34, F6, with out_last on F6; with the macro defined, out_sign=1 on all four.
REQ-034 out_ready held low 3 cycles while field 34 is shown -> out_data=34 and idx are stable, and the sequence resumes with 12.
REQ-035 Two words offered back-to-back (in_valid stays high) -> the 8 fields arrive in 8 consecutive cycles, and in_ready pulses only on each out_last handshake.
REQ-036 rst_n asserted after field 2 of a word -> all outputs read 0 immediately; after release in_ready=1 and the next word starts at field 0.
REQ-037 FIELD_W=32 build: accept 32'shFFFF_FFFF -> one field FFFFFFFF with out_last=1, and the next word is accepted in the same cycle.
